// File: rtl/simplecpu_core.sv
// Parametrised accumulator CPU: two-cycle FETCH/EXEC machine with Z/C flags, conditional branches, halt and a program-load port.
// Optional return stack is built when SIMPLECPU_STACK_EN is defined; otherwise CALL/RET behave as NOP.
module simplecpu_core #(
  parameter  int DATA_W     = 8,
  parameter  int PROG_DEPTH = 16,
  parameter  int OUT_PORTS  = 1,
  localparam int ADDR_W     = $clog2(PROG_DEPTH),
  localparam int INSTR_W    = 4 + DATA_W
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic                          load_en_i,
  input  logic                          load_we_i,
  input  logic [ADDR_W-1:0]             load_addr_i,
  input  logic [INSTR_W-1:0]            load_data_i,
  input  logic                          run_i,
  output logic [OUT_PORTS*DATA_W-1:0]   io_out,
  output logic [OUT_PORTS*DATA_W-1:0]   io_oeb,
  output logic                          halted_o,
  output logic                          fault_o,
  output logic [ADDR_W-1:0]             pc_o
);

  // state   | meaning
  // S_IDLE  | waiting for run_i; pc/acc/flags/stack/fault held cleared
  // S_FETCH | IR <= mem[pc], pc <= pc+1
  // S_EXEC  | execute IR, then FETCH or HALT
  // S_HALT  | stopped after HLT or stack fault; exits only via load_en_i or reset
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_JC  = 4'h9;
  localparam logic [3:0] OP_OUT = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   acc;
  logic                flag_z, flag_c;
  logic [INSTR_W-1:0]  ir;
  logic [INSTR_W-1:0]  mem [PROG_DEPTH];

  logic [3:0]          opcode;
  logic [DATA_W-1:0]   operand;
  logic [ADDR_W-1:0]   target;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, alu_wr;
  logic                clear, fetch_en, exec_en, stack_fault;

  assign opcode  = ir[INSTR_W-1:DATA_W];
  assign operand = ir[DATA_W-1:0];
  assign target  = operand[ADDR_W-1:0];
  assign pc_o    = pc;

  always_ff @(posedge wb_clk_i) begin
    if (load_en_i && load_we_i) mem[load_addr_i] <= load_data_i;
  end

`ifdef SIMPLECPU_STACK_EN
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;

  logic [ADDR_W-1:0] stack [4];
  logic [2:0]        sp;
  logic              fault_q;

  assign stack_fault = ((opcode == OP_CALL) && (sp == 3'd4)) ||
                       ((opcode == OP_RET)  && (sp == 3'd0));
  assign fault_o     = fault_q;

  always_ff @(posedge wb_clk_i) begin
    if (exec_en && (opcode == OP_CALL) && !stack_fault) stack[sp[1:0]] <= pc;
  end
`else
  assign stack_fault = 1'b0;
  assign fault_o     = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load_en_i) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run_i) state_nxt = S_FETCH;
        S_FETCH: state_nxt = S_EXEC;
        S_EXEC:  state_nxt = ((opcode == OP_HLT) || stack_fault) ? S_HALT : S_FETCH;
        default: state_nxt = S_HALT;
      endcase
    end
  end

  always_comb begin
    halted_o = (state == S_HALT);
    clear    = (state == S_IDLE) || load_en_i;
    fetch_en = (state == S_FETCH) && !load_en_i;
    exec_en  = (state == S_EXEC) && !load_en_i;
  end

  // C is only rewritten by ADD/SUB; logic ops and LDI keep the previous carry.
  always_comb begin
    alu_res = acc;
    alu_c   = flag_c;
    alu_wr  = 1'b0;
    case (opcode)
      OP_LDI: begin alu_res = operand; alu_wr = 1'b1; end
      OP_ADD: begin {alu_c, alu_res} = {1'b0, acc} + {1'b0, operand}; alu_wr = 1'b1; end
      OP_SUB: begin {alu_c, alu_res} = {1'b0, acc} - {1'b0, operand}; alu_wr = 1'b1; end
      OP_AND: begin alu_res = acc & operand; alu_wr = 1'b1; end
      OP_OR:  begin alu_res = acc | operand; alu_wr = 1'b1; end
      OP_XOR: begin alu_res = acc ^ operand; alu_wr = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pc     <= '0;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      ir     <= '0;
`ifdef SIMPLECPU_STACK_EN
      sp      <= 3'd0;
      fault_q <= 1'b0;
`endif
    end else if (clear) begin
      pc     <= '0;
      acc    <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
`ifdef SIMPLECPU_STACK_EN
      sp      <= 3'd0;
      fault_q <= 1'b0;
`endif
    end else if (fetch_en) begin
      ir <= mem[pc];
      pc <= pc + ADDR_W'(1);
    end else if (exec_en) begin
      if (alu_wr) begin
        acc    <= alu_res;
        flag_z <= (alu_res == '0);
        flag_c <= alu_c;
      end
      case (opcode)
        OP_JMP: pc <= target;
        OP_JZ:  if (flag_z) pc <= target;
        OP_JC:  if (flag_c) pc <= target;
`ifdef SIMPLECPU_STACK_EN
        OP_CALL: begin
          if (stack_fault) begin
            fault_q <= 1'b1;
          end else begin
            sp <= sp + 3'd1;
            pc <= target;
          end
        end
        OP_RET: begin
          if (stack_fault) begin
            fault_q <= 1'b1;
          end else begin
            sp <= sp - 3'd1;
            pc <= stack[sp[1:0] - 2'd1];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Output channels keep their values across IDLE; only reset or OUT changes them.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      io_out <= '0;
      io_oeb <= '1;
    end else if (exec_en && (opcode == OP_OUT)) begin
      for (int p = 0; p < OUT_PORTS; p++) begin
        if (operand == DATA_W'(p)) begin
          io_out[p*DATA_W +: DATA_W] <= acc;
          io_oeb[p*DATA_W +: DATA_W] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_simplecpu_core.sv
// Self-checking bench for simplecpu_core (DATA_W=8, PROG_DEPTH=16, OUT_PORTS=2).
// An instruction-level model predicts pc/outputs/halt/fault after each 2-cycle instruction.
module tb_simplecpu_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_en = 1'b0;
  logic        load_we = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [11:0] load_data = '0;
  logic        run = 1'b0;
  logic [15:0] io_out, io_oeb;
  logic        halted, fault;
  logic [3:0]  pc;

  simplecpu_core #(.DATA_W(8), .PROG_DEPTH(16), .OUT_PORTS(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .load_en_i(load_en), .load_we_i(load_we),
    .load_addr_i(load_addr), .load_data_i(load_data), .run_i(run),
    .io_out(io_out), .io_oeb(io_oeb), .halted_o(halted), .fault_o(fault), .pc_o(pc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int prog [16];
  int m_mem [16];
  int m_pc, m_acc;
  bit m_z, m_c, m_halt, m_fault;
  int m_out [2];
  bit m_en [2];
  int m_stk [$];

  function automatic int enc(input int op, input int v);
    return op * 256 + v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_out();
    return {16'h0, 8'(m_out[1]), 8'(m_out[0])};
  endfunction

  function automatic logic [31:0] exp_oeb();
    return {16'h0, {8{~m_en[1]}}, {8{~m_en[0]}}};
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".out"}, 32'(io_out), exp_out());
    chk({tag, ".oeb"}, 32'(io_oeb), exp_oeb());
    chk({tag, ".halt"}, 32'(halted), 32'(m_halt));
    chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
  endtask

  task automatic m_reset();
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_fault = 0;
    m_out[0] = 0; m_out[1] = 0; m_en[0] = 0; m_en[1] = 0;
    m_stk.delete();
  endtask

  // One whole instruction, described by the ISA rules rather than by cycles.
  task automatic m_step();
    int w, op, v;
    if (m_halt) return;
    w = m_mem[m_pc];
    m_pc = (m_pc + 1) % 16;
    op = w / 256;
    v = w % 256;
    case (op)
      1: m_acc = v;
      2: begin m_c = (m_acc + v) > 255; m_acc = (m_acc + v) % 256; end
      3: begin m_c = (m_acc < v); m_acc = (m_acc - v + 256) % 256; end
      4: m_acc = m_acc & v;
      5: m_acc = m_acc | v;
      6: m_acc = m_acc ^ v;
      7: m_pc = v % 16;
      8: if (m_z) m_pc = v % 16;
      9: if (m_c) m_pc = v % 16;
      10: if (v < 2) begin m_out[v] = m_acc; m_en[v] = 1; end
`ifdef SIMPLECPU_STACK_EN
      11: if (m_stk.size() == 4) begin m_fault = 1; m_halt = 1; end
          else begin m_stk.push_back(m_pc); m_pc = v % 16; end
      12: if (m_stk.size() == 0) begin m_fault = 1; m_halt = 1; end
          else m_pc = m_stk.pop_back();
`endif
      15: m_halt = 1;
      default: ;
    endcase
    if (op >= 1 && op <= 6) m_z = (m_acc == 0);
  endtask

  task automatic load_prog();
    load_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1;
      load_addr = 4'(i);
      load_data = 12'(prog[i]);
      @(negedge clk);
      m_mem[i] = prog[i];
    end
    load_we = 1'b0;
    load_en = 1'b0;
    m_pc = 0; m_halt = 0; m_fault = 0;
  endtask

  task automatic run_prog(input string tag, input int n);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    m_pc = 0; m_acc = 0; m_z = 0; m_c = 0; m_halt = 0; m_fault = 0;
    m_stk.delete();
    for (int k = 0; k < n; k++) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_step();
      check_all($sformatf("%s.s%0d", tag, k));
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 0;
  endtask

  initial begin
    int op, v;
    m_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Channels: OUT 1 drives the upper channel only, OUT 3 is ignored.
    clear_prog();
    prog[0] = enc(1, 8'hA5); prog[1] = enc(10, 1); prog[2] = enc(10, 3); prog[3] = enc(15, 0);
    load_prog();
    chk("load.pc", 32'(pc), 32'd0);
    run_prog("chan", 5);
    chk("chan.hi_out", 32'(io_out[15:8]), 32'hA5);
    chk("chan.hi_oeb", 32'(io_oeb[15:8]), 32'h00);
    chk("chan.lo_out", 32'(io_out[7:0]), 32'h00);
    chk("chan.lo_oeb", 32'(io_oeb[7:0]), 32'hFF);

    // LDI 5; ADD 3; OUT 0; HLT, then run_i pulses while halted.
    clear_prog();
    prog[0] = enc(1, 5); prog[1] = enc(2, 3); prog[2] = enc(10, 0); prog[3] = enc(15, 0);
    load_prog();
    run_prog("basic", 4);
    chk("basic.out0", 32'(io_out[7:0]), 32'd8);
    chk("basic.halted", 32'(halted), 32'd1);
    run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    check_all("basic.run_ignored");

    // Carry-taken branch skips word 3 and executes OUT at word 5.
    clear_prog();
    prog[0] = enc(1, 8'hFF); prog[1] = enc(2, 1); prog[2] = enc(9, 5); prog[3] = enc(10, 0);
    prog[4] = enc(15, 0); prog[5] = enc(10, 0); prog[6] = enc(15, 0);
    load_prog();
    run_prog("jc_taken", 6);
    chk("jc_taken.out0", 32'(io_out[7:0]), 32'h00);
    chk("jc_taken.oeb0", 32'(io_oeb[7:0]), 32'h00);
    chk("jc_taken.pc", 32'(pc), 32'd7);
    prog[1] = enc(2, 0);
    load_prog();
    run_prog("jc_untaken", 6);
    chk("jc_untaken.out0", 32'(io_out[7:0]), 32'hFF);
    chk("jc_untaken.pc", 32'(pc), 32'd5);

    // pc wraps from 15 to 0 through an untaken JZ at the last word.
    clear_prog();
    prog[15] = enc(8, 0);
    load_prog();
    run_prog("wrap", 20);
    chk("wrap.pc_end", 32'(pc), 32'd4);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    m_pc = 0;
    check_all("midload");
    repeat (4) @(negedge clk);
    check_all("midload.idle");

    // Reset in the middle of an EXEC cycle of OUT 0.
    clear_prog();
    prog[0] = enc(1, 8'h3C); prog[1] = enc(10, 0); prog[2] = enc(10, 1); prog[3] = enc(15, 0);
    load_prog();
    run_prog("prereset", 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all("async_reset");
    @(negedge clk);
    check_all("async_reset.held");
    rst_n = 1'b1;
    @(negedge clk);

    // Random programs against the instruction-level model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 0;
        v = (op == 10) ? $urandom_range(0, 3) : $urandom_range(0, 255);
        prog[i] = enc(op, v);
      end
      load_prog();
      run_prog($sformatf("rand%0d", r), 24);
    end

`ifdef SIMPLECPU_STACK_EN
    clear_prog();
    prog[0] = enc(11, 4); prog[1] = enc(10, 0); prog[2] = enc(15, 0);
    prog[4] = enc(11, 6); prog[5] = enc(12, 0); prog[6] = enc(11, 8); prog[7] = enc(12, 0);
    prog[8] = enc(11, 10); prog[9] = enc(12, 0); prog[10] = enc(1, 7); prog[11] = enc(12, 0);
    load_prog();
    run_prog("nest4", 13);
    chk("nest4.out0", 32'(io_out[7:0]), 32'd7);
    chk("nest4.fault", 32'(fault), 32'd0);
    prog[10] = enc(11, 12);
    load_prog();
    run_prog("nest5", 8);
    chk("nest5.fault", 32'(fault), 32'd1);
    chk("nest5.halted", 32'(halted), 32'd1);
    clear_prog();
    prog[0] = enc(12, 0);
    load_prog();
    chk("fault_cleared", 32'(fault), 32'd0);
    run_prog("ret0", 2);
    chk("ret0.fault", 32'(fault), 32'd1);
`else
    clear_prog();
    prog[0] = enc(1, 1); prog[1] = enc(11, 5); prog[2] = enc(12, 0);
    prog[3] = enc(10, 0); prog[4] = enc(15, 0);
    load_prog();
    run_prog("nostack", 6);
    chk("nostack.out0", 32'(io_out[7:0]), 32'd1);
    chk("nostack.fault", 32'(fault), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simplecpu_core.md
# simplecpu_core

Parametrised accumulator CPU: next generation of the user-area simple CPU. Adds configurable data width, program depth and output-channel count, a flag-based conditional-branch ISA, explicit halt and a synchronous program-load port. Sits inside user_project_wrapper. The load port is driven from la_data_in and the output channels drive io_out/io_oeb.

## Interface
- DATA_W, 8: accumulator, immediate and output-channel width. Must be ≥ ADDR_W.
- PROG_DEPTH, 16: program words. Must be a power of two, ≥ 2.
- OUT_PORTS, 1: number of DATA_W-wide output channels, 1..4.
- ADDR_W, $clog2(PROG_DEPTH): derived, not overridden.
- INSTR_W, 4+DATA_W: derived. Layout is opcode [INSTR_W-1:DATA_W], operand [DATA_W-1:0].
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_ni  in  1  asynchronous active-low reset.
- load_en_i  in  1  load mode. Forces IDLE.
- load_we_i  in  1  program write strobe. Honoured only when load_en_i=1.
- load_addr_i  in  ADDR_W  program write address.
- load_data_i  in  INSTR_W  program write data.
- run_i  in  1  start execution from IDLE.
- io_out  out  OUT_PORTS*DATA_W  output channels. Channel p is bits [p*DATA_W +: DATA_W].
- io_oeb  out  OUT_PORTS*DATA_W  active-low output enables, per channel.
- halted_o  out  1  CPU is in HALT.
- fault_o  out  1  stack fault, sticky until IDLE.
- pc_o  out  ADDR_W  current PC.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- Reset values:
  - state IDLE; pc, acc, Z, C and stack pointer 0.
  - io_out 0; io_oeb all 1; halted_o 0; fault_o 0.
  - Program memory is not reset.
- IDLE:
  - Entering IDLE clears pc, acc, Z, C, SP and fault_o.
  - io_out and io_oeb hold their values.
  - run_i=1 with load_en_i=0 → FETCH.
- load_en_i=1 forces IDLE at the next edge from any state and has priority over run_i.
- load_we_i=1 with load_en_i=1 writes mem[load_addr_i]=load_data_i.
- FETCH: IR ← mem[pc]; pc ← pc+1 mod PROG_DEPTH (wraps 15→0 at depth 16); → EXEC.
- EXEC: perform the opcode; → FETCH, or → HALT on HLT/fault.
- Opcodes (op = operand; a = op[ADDR_W-1:0]):
  - 0 NOP.
  - 1 LDI: acc=op; Z updated.
  - 2 ADD: {C,acc}=acc+op; Z updated.
  - 3 SUB: acc=acc−op; C=borrow; Z updated.
  - 4 AND, 5 OR, 6 XOR: acc=acc∘op; Z updated; C unchanged.
  - 7 JMP: pc=a.
  - 8 JZ: pc=a if Z.
  - 9 JC: pc=a if C.
  - A OUT: if op<OUT_PORTS, channel op ← acc and its io_oeb bits ← 0. Otherwise no effect.
  - B CALL, C RET: see Configuration.
  - D, E: NOP.
  - F HLT: → HALT.
- HALT: halted_o=1. Left only via load_en_i or reset. run_i is ignored.
- Arithmetic is mod 2^DATA_W. Operand bits above ADDR_W are ignored for jumps.
- Reset asserted mid-instruction aborts it immediately. No partial output update is allowed.

## Timing
- run_i sampled high at edge E0. Instruction k is fetched at edge E(2k+1) and executed at E(2k+2).
- Every instruction takes exactly 2 cycles. Taken and untaken branches cost the same.
- OUT results appear on io_out/io_oeb immediately after the EXEC edge.
- halted_o rises at the EXEC edge of HLT.
- load_en_i asserted before edge E forces state IDLE and pc_o=0 after E.
- A write and a FETCH never overlap, because a write requires load_en_i.

## Configuration
- SIMPLECPU_STACK_EN defined: 4-entry return stack.
  - CALL pushes pc (already incremented) and sets pc=a.
  - RET pops into pc.
  - CALL with 4 entries, or RET with 0 entries: fault_o=1 and state → HALT. Stack is unchanged.
- SIMPLECPU_STACK_EN undefined: opcodes B and C execute as NOP; no stack storage is built; fault_o is tied to 0.

## Test plan
- Reset: assert wb_rst_ni=0 mid-EXEC → io_out=0, io_oeb=all 1, halted_o=0, pc_o=0 asynchronously.
- DATA_W=8, program LDI 5; ADD 3; OUT 0; HLT, run at E0:
  - io_out[7:0]=8 and io_oeb[7:0]=0 after E6.
  - halted_o=1 after E8.
  - run_i pulses afterwards are ignored.
- Flags: LDI 0xFF; ADD 1; JC 5; OUT 0 (skipped); HLT; @5 OUT 0 → io_out=0x00 with io_oeb=0, via the taken branch. Repeat with ADD 0 → the untaken path executes the OUT at word 3.
- Channels (OUT_PORTS=2):
  - LDI 0xA5; OUT 1 → io_out[15:8]=0xA5, io_oeb[15:8]=0.
  - Channel 0 stays io_out=0, io_oeb=0xFF.
  - OUT 3 changes nothing.
- Wrap/load (PROG_DEPTH=16):
  - Words 0..14 NOP, word 15 JZ 0 with Z=0 → pc_o goes 15→0.
  - Assert load_en_i mid-run → IDLE after the next edge, pc_o=0, io_out held.
- SIMPLECPU_STACK_EN: 4 nested CALLs with matching RETs return correctly. A 5th nested CALL → fault_o=1, halted_o=1. RET at depth 0 → fault_o=1.
